// File: rtl/icon_dtree_hs.sv
// icon_dtree_hs: handshaked butterfly tree that steers each channel's words to the output lane named by their address MSBs.
// Latency: STAGES+1 register stages (1 injection + STAGES switch stages) with no contention and sinks ready.
// Backpressure: a word advances only into a free or emptying slot; ready ripples combinationally from i_ready to o_ready.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_valid/o_ready            per-channel injection handshake
//   i_addr/i_data              per-channel word; dest lane = i_addr[c][ADDR_W-1 -: STAGES]
//   o_valid/i_ready            per-lane delivery handshake
//   o_addr/o_data              delivered word (unchanged)
//   o_scb                      per-stage, per-node cross indication for the current cycle
//   o_busy                     any slot (injection or switch stage) holds a word
// Optional build macro ICON_DTREE_STATS_EN adds o_stall_cnt (cycles with a node conflict stall)
// and o_dlv_cnt (per-lane delivered words), both saturating 16-bit counters.
module icon_dtree_hs #(
    parameter int CHANS  = 4,
    parameter int EXPAND = 4,
    parameter int DATA_W = 7,
    parameter int ADDR_W = 9,
    localparam int OUTPUTS = CHANS * EXPAND,
    localparam int NODES   = OUTPUTS / 2,
    localparam int STAGES  = $clog2(OUTPUTS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [CHANS-1:0]               i_valid,
    output logic [CHANS-1:0]               o_ready,
    input  logic [CHANS-1:0][ADDR_W-1:0]   i_addr,
    input  logic [CHANS-1:0][DATA_W-1:0]   i_data,
    output logic [OUTPUTS-1:0]             o_valid,
    input  logic [OUTPUTS-1:0]             i_ready,
    output logic [OUTPUTS-1:0][ADDR_W-1:0] o_addr,
    output logic [OUTPUTS-1:0][DATA_W-1:0] o_data,
    output logic [STAGES-1:0][NODES-1:0]   o_scb,
`ifdef ICON_DTREE_STATS_EN
    output logic [15:0]                    o_stall_cnt,
    output logic [OUTPUTS-1:0][15:0]       o_dlv_cnt,
`endif
    output logic                           o_busy
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_t;

    // Lane a word wants at a stage: its own lane with the stage bit replaced by the dest bit.
    function automatic logic [STAGES-1:0] steer(input logic [STAGES-1:0] lane,
                                                input logic [ADDR_W-1:0] addr,
                                                input logic [STAGES-1:0] mask);
        logic [STAGES-1:0] dst;
        dst = addr[ADDR_W-1 -: STAGES];
        return (lane & ~mask) | (dst & mask);
    endfunction

    // Node number of a lane at a stage: the lane index with the stage bit removed.
    function automatic int node_of(input int lane, input int b);
        return ((lane >> (b + 1)) << b) | (lane & ((1 << b) - 1));
    endfunction

    // Registered state: injection slots plus one slot per lane per switch stage.
    logic [CHANS-1:0]   inj_vld;
    word_t              inj_w  [CHANS];
    logic [OUTPUTS-1:0] st_vld [STAGES];
    word_t              st_w   [STAGES][OUTPUTS];

    // Level view: level 0 is the injection slots spread onto their lanes, level k>0 is stage k-1.
    logic [OUTPUTS-1:0] lv_vld [STAGES+1];
    word_t              lv_w   [STAGES+1][OUTPUTS];
    logic [OUTPUTS-1:0] leave  [STAGES+1];   // slot's word moves on this cycle
    logic [OUTPUTS-1:0] in_vld [STAGES];     // stage slot is loaded this cycle
    word_t              in_w   [STAGES][OUTPUTS];
    logic [STAGES-1:0][NODES-1:0] scb;
`ifdef ICON_DTREE_STATS_EN
    logic               stall_any;
`endif

    always_comb begin
        logic [STAGES-1:0] lane;
        logic [STAGES-1:0] oth;
        logic [STAGES-1:0] mask;
        logic [STAGES-1:0] want;
        logic [STAGES-1:0] oth_want;
        logic              lose;
        logic              free;

        lane     = '0;
        oth      = '0;
        mask     = '0;
        want     = '0;
        oth_want = '0;
        lose     = 1'b0;
        free     = 1'b0;
        scb      = '0;
`ifdef ICON_DTREE_STATS_EN
        stall_any = 1'b0;
`endif
        for (int k = 0; k <= STAGES; k++) begin
            lv_vld[k] = '0;
            leave[k]  = '0;
            for (int l = 0; l < OUTPUTS; l++) begin
                lv_w[k][l] = '0;
            end
        end
        for (int s = 0; s < STAGES; s++) begin
            in_vld[s] = '0;
            for (int l = 0; l < OUTPUTS; l++) begin
                in_w[s][l] = '0;
            end
        end

        for (int c = 0; c < CHANS; c++) begin
            lv_vld[0][c*EXPAND] = inj_vld[c];
            lv_w[0][c*EXPAND]   = inj_w[c];
        end
        for (int s = 0; s < STAGES; s++) begin
            lv_vld[s+1] = st_vld[s];
            for (int l = 0; l < OUTPUTS; l++) begin
                lv_w[s+1][l] = st_w[s][l];
            end
        end

        // Resolve from the sinks backwards so every slot knows whether its target empties.
        leave[STAGES] = i_rst ? '0 : (st_vld[STAGES-1] & i_ready);
        for (int s = STAGES - 1; s >= 0; s--) begin
            for (int l = 0; l < OUTPUTS; l++) begin
                lane     = STAGES'(l);
                mask     = STAGES'(1 << (STAGES - 1 - s));
                oth      = lane ^ mask;
                want     = steer(lane, lv_w[s][l].addr, mask);
                oth_want = steer(oth, lv_w[s][oth].addr, mask);
                // Lower source lane wins a shared target; the loser holds its slot.
                lose     = lv_vld[s][oth] && (oth_want == want) && (oth < lane);
                free     = !lv_vld[s+1][want] || leave[s+1][want];
`ifdef ICON_DTREE_STATS_EN
                if (lv_vld[s][l] && lose && !i_rst) begin
                    stall_any = 1'b1;
                end
`endif
                if (lv_vld[s][l] && !lose && free && !i_rst) begin
                    leave[s][l]     = 1'b1;
                    in_vld[s][want] = 1'b1;
                    in_w[s][want]   = lv_w[s][l];
                    if (want != lane) begin
                        scb[s][node_of(l, STAGES - 1 - s)] = 1'b1;
                    end
                end
            end
        end
    end

    // Injection slot accepts when empty or draining; held low during reset.
    always_comb begin
        for (int c = 0; c < CHANS; c++) begin
            o_ready[c] = !i_rst && (!inj_vld[c] || leave[0][c*EXPAND]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inj_vld <= '0;
            for (int c = 0; c < CHANS; c++) begin
                inj_w[c] <= '0;
            end
            for (int s = 0; s < STAGES; s++) begin
                st_vld[s] <= '0;
                for (int l = 0; l < OUTPUTS; l++) begin
                    st_w[s][l] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < CHANS; c++) begin
                if (i_valid[c] && o_ready[c]) begin
                    inj_vld[c] <= 1'b1;
                    inj_w[c]   <= '{addr: i_addr[c], data: i_data[c]};
                end else if (leave[0][c*EXPAND]) begin
                    inj_vld[c] <= 1'b0;
                end
            end
            for (int s = 0; s < STAGES; s++) begin
                for (int l = 0; l < OUTPUTS; l++) begin
                    if (in_vld[s][l]) begin
                        st_vld[s][l] <= 1'b1;
                        st_w[s][l]   <= in_w[s][l];
                    end else if (leave[s+1][l]) begin
                        st_vld[s][l] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        o_valid = st_vld[STAGES-1];
        o_scb   = scb;
        o_busy  = |inj_vld;
        for (int l = 0; l < OUTPUTS; l++) begin
            o_addr[l] = st_w[STAGES-1][l].addr;
            o_data[l] = st_w[STAGES-1][l].data;
        end
        for (int s = 0; s < STAGES; s++) begin
            o_busy = o_busy | (|st_vld[s]);
        end
    end

`ifdef ICON_DTREE_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
            o_dlv_cnt   <= '0;
        end else begin
            if (stall_any && o_stall_cnt != 16'hFFFF) begin
                o_stall_cnt <= o_stall_cnt + 16'd1;
            end
            for (int l = 0; l < OUTPUTS; l++) begin
                if (o_valid[l] && i_ready[l] && o_dlv_cnt[l] != 16'hFFFF) begin
                    o_dlv_cnt[l] <= o_dlv_cnt[l] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_icon_dtree_hs.sv
// tb_icon_dtree_hs: directed vectors and corner sequences for icon_dtree_hs.
// Latency: n/a.
// Backpressure: exercises sink stalls on one lane.
module tb_icon_dtree_hs;

    localparam int CH = 4, EX = 4, DW = 7, AW = 9, NO = 16, ST = 4, ND = 8;

    logic                   i_clk;
    logic                   i_rst;
    logic [CH-1:0]          i_valid;
    logic [CH-1:0]          o_ready;
    logic [CH-1:0][AW-1:0]  i_addr;
    logic [CH-1:0][DW-1:0]  i_data;
    logic [NO-1:0]          o_valid;
    logic [NO-1:0]          i_ready;
    logic [NO-1:0][AW-1:0]  o_addr;
    logic [NO-1:0][DW-1:0]  o_data;
    logic [ST-1:0][ND-1:0]  o_scb;
    logic                   o_busy;

    // Second instance: 2 channels x 8 lanes, 4-bit address.
    logic [1:0]             b_valid;
    logic [1:0]             b_ready;
    logic [1:0][3:0]        b_addr;
    logic [1:0][DW-1:0]     b_data;
    logic [NO-1:0]          b_ovalid;
    logic [NO-1:0]          b_iready;
    logic [NO-1:0][3:0]     b_oaddr;
    logic [NO-1:0][DW-1:0]  b_odata;
    logic [ST-1:0][ND-1:0]  b_scb;
    logic                   b_busy;
`ifdef ICON_DTREE_STATS_EN
    logic [15:0]            o_stall_cnt;
    logic [NO-1:0][15:0]    o_dlv_cnt;
    logic [15:0]            b_stall_cnt;
    logic [NO-1:0][15:0]    b_dlv_cnt;
`endif

    icon_dtree_hs #(.CHANS(CH), .EXPAND(EX), .DATA_W(DW), .ADDR_W(AW)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_valid), .o_ready(o_ready), .i_addr(i_addr), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_addr(o_addr), .o_data(o_data),
        .o_scb(o_scb),
`ifdef ICON_DTREE_STATS_EN
        .o_stall_cnt(o_stall_cnt), .o_dlv_cnt(o_dlv_cnt),
`endif
        .o_busy(o_busy)
    );

    icon_dtree_hs #(.CHANS(2), .EXPAND(8), .DATA_W(DW), .ADDR_W(4)) u_dut6 (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(b_valid), .o_ready(b_ready), .i_addr(b_addr), .i_data(b_data),
        .o_valid(b_ovalid), .i_ready(b_iready), .o_addr(b_oaddr), .o_data(b_odata),
        .o_scb(b_scb),
`ifdef ICON_DTREE_STATS_EN
        .o_stall_cnt(b_stall_cnt), .o_dlv_cnt(b_dlv_cnt),
`endif
        .o_busy(b_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    typedef struct {
        logic [CH-1:0]          vld;
        logic [CH-1:0][AW-1:0]  addr;
        logic [CH-1:0][DW-1:0]  data;
        logic [NO-1:0]          exp_vld;
        logic [ST*ND-1:0]       exp_scb;
    } vec_t;

    vec_t             vecs [5];
    logic [ST*ND-1:0] scb_acc;
    logic [NO-1:0]    vacc;
    int               sent, got, stray;
    logic             in_x, seen;

    initial begin
        // Packed arrays list ch3 first.
        vecs[0] = '{vld: 4'b0001, addr: {9'h000, 9'h000, 9'h000, 9'h1F0},
                    data: {7'h00, 7'h00, 7'h00, 7'h55}, exp_vld: 16'h8000, exp_scb: 32'h8040_1001};
        vecs[1] = '{vld: 4'b1111, addr: {9'h1E0, 9'h140, 9'h0A0, 9'h000},
                    data: {7'h0F, 7'h2A, 7'h5A, 7'h71}, exp_vld: 16'h8421, exp_scb: 32'h8450_0000};
        vecs[2] = '{vld: 4'b1111, addr: {9'h000, 9'h080, 9'h100, 9'h180},
                    data: {7'h33, 7'h40, 7'h7F, 7'h01}, exp_vld: 16'h1111, exp_scb: 32'h0000_1111};
        vecs[3] = '{vld: 4'b0010, addr: {9'h000, 9'h000, 9'h033, 9'h000},
                    data: {7'h00, 7'h00, 7'h6B, 7'h00}, exp_vld: 16'h0002, exp_scb: 32'h0100_0100};
        vecs[4] = '{vld: 4'b1000, addr: {9'h0DF, 9'h000, 9'h000, 9'h000},
                    data: {7'h2D, 7'h00, 7'h00, 7'h00}, exp_vld: 16'h0040, exp_scb: 32'h0004_0010};

        i_rst    = 1'b1;
        i_valid  = '0;
        i_addr   = '0;
        i_data   = '0;
        i_ready  = '1;
        b_valid  = '0;
        b_addr   = '0;
        b_data   = '0;
        b_iready = '1;

        // Reset state
        tick();
        tick();
        chk("rst_o_valid", 64'(o_valid), 64'(0));
        chk("rst_o_ready", 64'(o_ready), 64'(0));
        chk("rst_o_busy",  64'(o_busy),  64'(0));
        chk("rst_o_scb",   64'(o_scb),   64'(0));
        i_rst = 1'b0;
        #1;
        chk("rst_release_ready", 64'(o_ready), 64'(4'hF));

        // Table vectors: latency, steering, payload/address integrity, switch path
        for (int v = 0; v < 5; v++) begin
            scb_acc = '0;
            chk("vec_ready_idle", 64'(o_ready), 64'(4'hF));
            i_valid = vecs[v].vld;
            i_addr  = vecs[v].addr;
            i_data  = vecs[v].data;
            tick();
            i_valid = '0;
            scb_acc = scb_acc | o_scb;
            for (int t = 0; t < 3; t++) begin
                tick();
                scb_acc = scb_acc | o_scb;
            end
            chk("vec_not_early", 64'(o_valid), 64'(0));
            tick();
            scb_acc = scb_acc | o_scb;
            chk("vec_o_valid", 64'(o_valid), 64'(vecs[v].exp_vld));
            for (int l = 0; l < NO; l++) begin
                for (int c = 0; c < CH; c++) begin
                    if (vecs[v].vld[c] && vecs[v].addr[c][AW-1 -: ST] == 4'(l)) begin
                        chk("vec_lane_data", 64'(o_data[l]), 64'(vecs[v].data[c]));
                        chk("vec_lane_addr", 64'(o_addr[l]), 64'(vecs[v].addr[c]));
                    end
                end
            end
            chk("vec_scb_path", 64'(scb_acc), 64'(vecs[v].exp_scb));
            tick();
            chk("vec_drained_valid", 64'(o_valid), 64'(0));
            chk("vec_drained_busy", 64'(o_busy), 64'(0));
        end

        // Conflict: ch0 and ch1 both to dest 7
        i_valid   = 4'b0011;
        i_addr[0] = 9'h0E0;
        i_data[0] = 7'h11;
        i_addr[1] = 9'h0E0;
        i_data[1] = 7'h22;
        tick();
        i_valid = '0;
        for (int t = 0; t < 4; t++) tick();
        chk("conf_first_valid", 64'(o_valid), 64'(16'h0080));
        chk("conf_first_data", 64'(o_data[7]), 64'(7'h11));
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            tick();
            if (o_valid[7]) begin
                seen = 1'b1;
                chk("conf_second_data", 64'(o_data[7]), 64'(7'h22));
            end
        end
        chk("conf_second_seen", 64'(seen), 64'(1));
        tick();
        chk("conf_drained", 64'(o_busy), 64'(0));
`ifdef ICON_DTREE_STATS_EN
        chk("conf_stall_cnt", 64'(o_stall_cnt != 16'd0), 64'(1));
`endif

        // Backpressure: lane 3 blocked, ch0 streams 8 words to dest 3
        i_ready[3] = 1'b0;
        sent = 0;
        got  = 0;
        stray = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            i_valid[0] = (sent < 8);
            i_addr[0]  = 9'h060 | 9'(sent);
            i_data[0]  = 7'h30 + 7'(sent);
            #1;
            in_x = i_valid[0] & o_ready[0];
            tick();
            if (in_x) sent++;
        end
        chk("bp_words_held", 64'(sent), 64'(5));
        chk("bp_ready_low", 64'(o_ready[0]), 64'(0));
        chk("bp_head_valid", 64'(o_valid), 64'(16'h0008));
        chk("bp_head_data", 64'(o_data[3]), 64'(7'h30));
        chk("bp_busy", 64'(o_busy), 64'(1));
        i_ready = '1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            i_valid[0] = (sent < 8);
            i_addr[0]  = 9'h060 | 9'(sent);
            i_data[0]  = 7'h30 + 7'(sent);
            #1;
            in_x = i_valid[0] & o_ready[0];
            if ((o_valid & ~16'h0008) != '0) stray++;
            if (o_valid[3]) begin
                chk("bp_order_data", 64'(o_data[3]), 64'(7'h30 + 7'(got)));
                got++;
            end
            tick();
            if (in_x) sent++;
        end
        i_valid = '0;
        chk("bp_all_sent", 64'(sent), 64'(8));
        chk("bp_all_delivered", 64'(got), 64'(8));
        chk("bp_no_stray_lane", 64'(stray), 64'(0));
`ifdef ICON_DTREE_STATS_EN
        chk("bp_dlv_cnt_lane3", 64'(o_dlv_cnt[3]), 64'(8));
`endif

        // Reset mid-flight flushes all words
        i_valid   = 4'b0111;
        i_addr[0] = 9'h040;
        i_data[0] = 7'h0A;
        i_addr[1] = 9'h120;
        i_data[1] = 7'h0B;
        i_addr[2] = 9'h1A0;
        i_data[2] = 7'h0C;
        tick();
        i_valid = '0;
        tick();
        tick();
        chk("flush_busy_before", 64'(o_busy), 64'(1));
        i_rst = 1'b1;
        tick();
        chk("flush_valid", 64'(o_valid), 64'(0));
        chk("flush_busy", 64'(o_busy), 64'(0));
        chk("flush_ready_in_rst", 64'(o_ready), 64'(0));
        i_rst = 1'b0;
        #1;
        chk("flush_ready_after", 64'(o_ready), 64'(4'hF));
        vacc = '0;
        for (int t = 0; t < 8; t++) begin
            tick();
            vacc = vacc | o_valid;
        end
        chk("flush_no_old_words", 64'(vacc), 64'(0));
        i_valid   = 4'b0100;
        i_addr[2] = 9'h125;
        i_data[2] = 7'h3C;
        tick();
        i_valid = '0;
        for (int t = 0; t < 4; t++) tick();
        chk("post_rst_valid", 64'(o_valid), 64'(16'h0200));
        chk("post_rst_data", 64'(o_data[9]), 64'(7'h3C));
        chk("post_rst_addr", 64'(o_addr[9]), 64'(9'h125));

        // Alternate geometry: ch1 (lane 8) to dest 9, one crossing at stage 3 node 4
        chk("g2_ready_idle", 64'(b_ready), 64'(2'b11));
        b_valid   = 2'b10;
        b_addr[1] = 4'h9;
        b_data[1] = 7'h4E;
        scb_acc   = '0;
        tick();
        b_valid = '0;
        scb_acc = scb_acc | b_scb;
        for (int t = 0; t < 3; t++) begin
            tick();
            scb_acc = scb_acc | b_scb;
        end
        chk("g2_not_early", 64'(b_ovalid), 64'(0));
        tick();
        scb_acc = scb_acc | b_scb;
        chk("g2_valid", 64'(b_ovalid), 64'(16'h0200));
        chk("g2_data", 64'(b_odata[9]), 64'(7'h4E));
        chk("g2_scb_path", 64'(scb_acc), 64'(32'h1000_0000));
        tick();
        chk("g2_drained", 64'(b_busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
